// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle between the fetch stage, the MEM stage, the shared memory
// and the port arbiter. The arbiter connects through the slave modport.
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        if_stall;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;

    logic [1:0]  mem_cmd;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata,
        input  mem_ready, mem_rvalid, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, if_stall,
        output d_gnt, d_rvalid, d_rdata,
        output mem_cmd, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata,
        output mem_ready, mem_rvalid, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, if_stall,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_cmd, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and the load/store unit.
// Data wins by default; after STARVE_MAX denied fetch cycles, fetch is forced through.
module mem_port_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT_I, WAIT_D} state_t;

    localparam logic [1:0] CMD_NONE  = 2'd0;
    localparam logic [1:0] CMD_LOAD  = 2'd1;
    localparam logic [1:0] CMD_STORE = 2'd2;
    localparam logic [3:0] STARVE_LIMIT = 4'(STARVE_MAX);

    state_t      state_q, state_d;
    logic [3:0]  starve_cnt_q, starve_cnt_d;
    logic        if_rvalid_q, if_rvalid_d;
    logic        d_rvalid_q, d_rvalid_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;

    logic issue_ok;
    logic fetch_win;
    logic data_win;
    logic unused_addr_bits;

    // The cycle a response pulse is visible is already IDLE, but must not issue.
    assign issue_ok  = ~rst & (state_q == IDLE) & bus.mem_ready & ~if_rvalid_q & ~d_rvalid_q;
    assign fetch_win = issue_ok & bus.if_req & (~bus.d_req | (starve_cnt_q == STARVE_LIMIT));
    assign data_win  = issue_ok & bus.d_req & ~fetch_win;

    assign bus.if_gnt    = fetch_win;
    assign bus.d_gnt     = data_win;
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.if_stall  = bus.if_req & ~if_rvalid_q;

    assign bus.mem_cmd   = fetch_win ? CMD_LOAD :
                           data_win  ? (bus.d_we ? CMD_STORE : CMD_LOAD) : CMD_NONE;
    assign bus.mem_addr  = fetch_win ? {bus.if_addr[31:2], 2'b00} :
                           data_win  ? {bus.d_addr[31:2], 2'b00} : 32'h0;
    assign bus.mem_wdata = (data_win & bus.d_we) ? bus.d_wdata : 32'h0;

    assign unused_addr_bits = ^{bus.if_addr[1:0], bus.d_addr[1:0]};

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        if_rvalid_d  = 1'b0;
        d_rvalid_d   = 1'b0;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;

        unique case (state_q)
            IDLE: begin
                if (fetch_win) begin
                    state_d = WAIT_I;
                end else if (data_win & ~bus.d_we) begin
                    state_d = WAIT_D;
                end
            end
            WAIT_I: begin
                if (bus.mem_rvalid) begin
                    if_rdata_d  = bus.mem_rdata;
                    if_rvalid_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            WAIT_D: begin
                if (bus.mem_rvalid) begin
                    d_rdata_d  = bus.mem_rdata;
                    d_rvalid_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Counts every cycle fetch wants the port but does not get it, waits included.
        if (fetch_win) begin
            starve_cnt_d = 4'd0;
        end else if (bus.if_req && (starve_cnt_q != STARVE_LIMIT)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            starve_cnt_q <= 4'd0;
            if_rvalid_q  <= 1'b0;
            d_rvalid_q   <= 1'b0;
            if_rdata_q   <= 32'h0;
            d_rdata_q    <= 32'h0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            if_rvalid_q  <= if_rvalid_d;
            d_rvalid_q   <= d_rvalid_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end
endmodule
